lfsr_encrypt_engine: RTL and testbench

Hardware encryptor for Program 1, the encrypt direction of the LFSR message-cipher flow. It reads the plaintext message, preamble length, tap pattern and seed from data memory, then writes 64 ciphertext bytes to DM[64:127]. Those bytes are exactly what the Program 2 decrypter consumes. It sits beside the data memory in `top_level` and is launched and acknowledged with the same req/ack handshake as the programmable core.

---
 rtl/lfsr_pkg.sv | 35 +++
 rtl/lfsr7_step.sv | 26 ++
 rtl/lfsr_encrypt_engine.sv | 129 ++++++++++++
 tb/tb_lfsr_encrypt_engine.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR message cipher (encrypt and decrypt engines).
package lfsr_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_PRE  = 3'd1,
    LD_TAP  = 3'd2,
    LD_SEED = 3'd3,
    RD      = 3'd4,
    WR      = 3'd5,
    DONE    = 3'd6
  } enc_state_t;

  localparam int unsigned LFSR_W    = 7;
  localparam int unsigned IDX_W     = 7;
  localparam logic [7:0]  PRE_ADDR  = 8'd61;
  localparam logic [7:0]  TAP_ADDR  = 8'd62;
  localparam logic [7:0]  SEED_ADDR = 8'd63;
  localparam logic [7:0]  ASCII_SPACE = 8'h20;

  // Message storage occupies DM[0 .. PRE_ADDR-1].
  localparam logic [7:0]  MSG_CHARS = PRE_ADDR;

  localparam logic [LFSR_W-1:0] LEGAL_TAPS [9] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  // True when padded-frame index idx maps onto a stored message byte.
  function automatic logic pt_in_msg(input logic [IDX_W-1:0] idx, input logic [5:0] pre);
    logic [7:0] off;
    off = 8'(idx) - 8'(pre);
    return (idx >= IDX_W'(pre)) && (off < MSG_CHARS);
  endfunction

endpackage

// File: rtl/lfsr7_step.sv
// 7-bit Fibonacci-style LFSR register: load (with optional zero-seed substitution) and advance.
module lfsr7_step
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              init_n,
  input  logic              load,
  input  logic              zero_sub,
  input  logic [LFSR_W-1:0] seed,
  input  logic              advance,
  input  logic [LFSR_W-1:0] taps,
  output logic [LFSR_W-1:0] q
);

  // An all-zero state would lock the LFSR, so a zero seed may be replaced by 1.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      q <= '0;
    end else if (load) begin
      q <= (zero_sub && (seed == '0)) ? LFSR_W'(1) : seed;
    end else if (advance) begin
      q <= {q[LFSR_W-2:0], ^(q & taps)};
    end
  end

endmodule

// File: rtl/lfsr_encrypt_engine.sv
// Program 1 encryptor: reads preamble/taps/seed and plaintext from DM, writes 64 cipher bytes.
// Optional build macro LFSR_PARITY_EN: replaces bit 7 of each cipher byte with parity of [6:0].
module lfsr_encrypt_engine
  import lfsr_pkg::*;
#(
  parameter int unsigned NUM_CHARS = 64,
  parameter int unsigned CT_BASE   = 64
) (
  input  logic       clk,
  input  logic       init_n,
  input  logic       req,
  output logic       ack,
  output logic [7:0] dm_addr,
  input  logic [7:0] dm_rd_data,
  output logic       dm_wr_en,
  output logic [7:0] dm_wr_data
);

  enc_state_t        state;
  logic              req_q;
  logic [IDX_W-1:0]  i;
  logic [5:0]        pre_len;
  logic [LFSR_W-1:0] taps;
  logic [LFSR_W-1:0] lfsr;

  logic              lfsr_load_c;
  logic              lfsr_adv_c;
  logic [IDX_W-1:0]  rd_idx_c;
  logic [7:0]        rd_addr_c;
  logic [7:0]        pt_c;
  logic [7:0]        cipher_c;
  logic [7:0]        wr_byte_c;

  lfsr7_step u_lfsr (
    .clk      (clk),
    .init_n   (init_n),
    .load     (lfsr_load_c),
    .zero_sub (1'b1),
    .seed     (dm_rd_data[LFSR_W-1:0]),
    .advance  (lfsr_adv_c),
    .taps     (taps),
    .q        (lfsr)
  );

  // LFSR controls, next read address and the cipher byte for the current character.
  always_comb begin
    lfsr_load_c = (state == LD_SEED);
    lfsr_adv_c  = (state == WR);
    rd_idx_c    = (state == WR) ? (i + IDX_W'(1)) : i;
    rd_addr_c   = pt_in_msg(rd_idx_c, pre_len) ? (8'(rd_idx_c) - 8'(pre_len)) : 8'h00;
    pt_c        = pt_in_msg(i, pre_len) ? dm_rd_data : ASCII_SPACE;
    cipher_c    = (pt_c - ASCII_SPACE) ^ {1'b0, lfsr};
`ifdef LFSR_PARITY_EN
    wr_byte_c   = {^cipher_c[6:0], cipher_c[6:0]};
`else
    wr_byte_c   = cipher_c;
`endif
  end

  // Run sequencer; memory-side outputs are registered on entry to the state that uses them.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state      <= IDLE;
      req_q      <= 1'b0;
      i          <= '0;
      pre_len    <= '0;
      taps       <= '0;
      ack        <= 1'b0;
      dm_addr    <= '0;
      dm_wr_en   <= 1'b0;
      dm_wr_data <= '0;
    end else begin
      req_q    <= req;
      dm_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          ack <= 1'b0;
          if (req_q && !req) begin
            i       <= '0;
            dm_addr <= PRE_ADDR;
            state   <= LD_PRE;
          end
        end
        LD_PRE: begin
          pre_len <= dm_rd_data[5:0];
          dm_addr <= TAP_ADDR;
          state   <= LD_TAP;
        end
        LD_TAP: begin
          taps    <= dm_rd_data[LFSR_W-1:0];
          dm_addr <= SEED_ADDR;
          state   <= LD_SEED;
        end
        LD_SEED: begin
          dm_addr <= rd_addr_c;
          state   <= RD;
        end
        RD: begin
          dm_addr    <= 8'(CT_BASE) + 8'(i);
          dm_wr_en   <= 1'b1;
          dm_wr_data <= wr_byte_c;
          state      <= WR;
        end
        WR: begin
          if (i == IDX_W'(NUM_CHARS - 1)) begin
            dm_addr <= '0;
            state   <= DONE;
          end else begin
            i       <= i + IDX_W'(1);
            dm_addr <= rd_addr_c;
            state   <= RD;
          end
        end
        DONE: begin
          if (req) begin
            ack   <= 1'b0;
            state <= IDLE;
          end else begin
            ack <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// Bench for lfsr_encrypt_engine; expectations follow LFSR_PARITY_EN when it is defined.
module tb_lfsr_encrypt_engine;

  logic       clk;
  logic       init_n;
  logic       req;
  logic       ack;
  logic [7:0] dm_addr;
  logic [7:0] dm_rd_data;
  logic       dm_wr_en;
  logic [7:0] dm_wr_data;

  logic [7:0] mem [256];
  logic [15:0] exp_q [$];
  int tests = 0;
  int fails = 0;
  int hi_reads = 0;

  lfsr_encrypt_engine #(.NUM_CHARS(64), .CT_BASE(64)) dut (
    .clk        (clk),
    .init_n     (init_n),
    .req        (req),
    .ack        (ack),
    .dm_addr    (dm_addr),
    .dm_rd_data (dm_rd_data),
    .dm_wr_en   (dm_wr_en),
    .dm_wr_data (dm_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_rd_data = mem[dm_addr];

  always @(posedge clk) begin
    if (dm_wr_en) mem[dm_addr] <= dm_wr_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe pops one expected {addr,data}; also counts config-address reads.
  always @(negedge clk) begin
    logic [15:0] e;
    if (init_n && dm_wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {16'h0, dm_addr, dm_wr_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(dm_addr), 32'(e[15:8]));
        chk("wr_data", 32'(dm_wr_data), 32'(e[7:0]));
      end
    end
    if (init_n && !dm_wr_en && dm_addr >= 8'd61 && dm_addr <= 8'd63) hi_reads++;
  end

  // Bench model of the whole frame: queue 64 expected writes from current memory contents.
  task automatic push_expected();
    logic [6:0] l;
    logic [6:0] t;
    logic [5:0] pre;
    logic [7:0] p;
    logic [7:0] c;
    pre = mem[61][5:0];
    t   = mem[62][6:0];
    l   = (mem[63][6:0] == 7'h00) ? 7'h01 : mem[63][6:0];
    for (int k = 0; k < 64; k++) begin
      if (k < int'(pre) || (k - int'(pre)) >= 61) p = 8'h20;
      else p = mem[k - int'(pre)];
      c = (p - 8'h20) ^ {1'b0, l};
`ifdef LFSR_PARITY_EN
      c[7] = ^c[6:0];
`endif
      exp_q.push_back({8'(64 + k), c});
      l = {l[5:0], ^(l & t)};
    end
  endtask

  task automatic setup_mem(input string msg, input logic [7:0] pre, input logic [7:0] tp,
                           input logic [7:0] sd);
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    for (int k = 0; k < 61; k++) mem[k] = (k < msg.len()) ? msg[k] : 8'h20;
    mem[61] = pre;
    mem[62] = tp;
    mem[63] = sd;
  endtask

  // Returns at launch edge E.
  task automatic launch();
    @(negedge clk) req = 1'b1;
    @(negedge clk) req = 1'b0;
    @(posedge clk);
  endtask

  // From edge E: ack low through E+131, high after E+132, all writes consumed.
  task automatic wait_ack(input string tag);
    repeat (131) @(posedge clk);
    #1 chk({tag, "_ack_early"}, 32'(ack), 32'd0);
    @(posedge clk);
    #1 chk({tag, "_ack_E132"}, 32'(ack), 32'd1);
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic release_req(input string tag);
    @(negedge clk) req = 1'b1;
    @(posedge clk);
    #1 chk({tag, "_ack_fall"}, 32'(ack), 32'd0);
  endtask

  initial begin
    string watson;
    string longmsg;
    watson = "Mr. Watson, come here. I want to see you.";
    longmsg = "";
    for (int k = 0; k < 53; k++) longmsg = {longmsg, string'(8'(8'h41 + 8'(k % 26)))};
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;
    init_n = 1'b0;
    req    = 1'b1;
    #12;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_addr", 32'(dm_addr), 32'd0);
    chk("rst_wr_en", 32'(dm_wr_en), 32'd0);
    chk("rst_wr_data", 32'(dm_wr_data), 32'd0);
    @(negedge clk) init_n = 1'b1;

    // Watson message, taps 5C, seed 35, preamble 10
    setup_mem(watson, 8'd10, 8'h5C, 8'h35);
    push_expected();
    launch();
    wait_ack("watson");
    chk("watson_dm64", 32'(mem[64]), 32'h35);
    chk("watson_dm65", 32'(mem[65]), 32'h6A);
    release_req("watson");

    // Zero seed substitution, all-space memory
    setup_mem("", 8'd12, 8'h60, 8'h00);
    push_expected();
    launch();
    wait_ack("zseed");
`ifdef LFSR_PARITY_EN
    chk("zseed_dm64", 32'(mem[64]), 32'h81);
    chk("zseed_dm65", 32'(mem[65]), 32'h82);
`else
    chk("zseed_dm64", 32'(mem[64]), 32'h01);
    chk("zseed_dm65", 32'(mem[65]), 32'h02);
`endif
    // Hold req low after ack: ack stays, no further writes
    repeat (20) @(posedge clk);
    #1 chk("hold_ack", 32'(ack), 32'd1);
    release_req("hold");

    // Reset 50 cycles into a run, then a clean relaunch
    setup_mem(watson, 8'd10, 8'h5C, 8'h35);
    push_expected();
    launch();
    repeat (50) @(posedge clk);
    #2 init_n = 1'b0;
    #1 chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_wr_en", 32'(dm_wr_en), 32'd0);
    exp_q.delete();
    @(negedge clk) init_n = 1'b1;
    setup_mem(watson, 8'd10, 8'h5C, 8'h35);
    push_expected();
    launch();
    wait_ack("relaunch");
    chk("relaunch_dm64", 32'(mem[64]), 32'h35);
    release_req("relaunch");

    // Preamble 26 with a 53-char message: only the three config addresses above 60 are read
    setup_mem(longmsg, 8'd26, 8'h7B, 8'h5A);
    push_expected();
    hi_reads = 0;
    launch();
    wait_ack("pre26");
    chk("pre26_hi_reads", 32'(hi_reads), 32'd3);
    chk("pre26_dm64", 32'(mem[64]), 32'h5A);
    release_req("pre26");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
